// File: rtl/sha_compressor.sv
// rtl/sha_compressor.sv - SHA-256 compression engine folding a 64-word expanded schedule into a 256-bit digest
//
// Optional feature macro: SHA_MIDSTATE_EN
//   defined     : chaining value is taken from h_in at acceptance (multi-block messages, miner midstates)
//   not defined : h_in is ignored and the fixed SHA-256 IV is used as chaining value
//
// Parameter:
//   UNROLL    : rounds evaluated per clock, legal values 1, 2, 4
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : w / h_in valid
//   in_ready  : engine idle, block accepted on in_valid && in_ready
//   w         : expanded schedule, Wt at w[2047-32t -: 32]
//   h_in      : chaining value H0..H7, H0 at [255:224]
//   out_valid : one-cycle pulse, digest valid
//   digest    : result H0..H7, H0 at [255:224], held until the next result
module sha_compressor #(
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2047:0]   w,
    input  logic [255:0]    h_in,
    output logic            out_valid,
    output logic [255:0]    digest
);

    localparam int         SHIFT  = 32 * UNROLL;
    localparam logic [6:0] LAST_T = 7'(64 - UNROLL);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // K[0] sits in the most significant word, same ordering as w.
    localparam logic [2047:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $fatal(1, "sha_compressor: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [6:0]     t;
    logic [2047:0]  sched;
    logic [255:0]   work;
    logic [255:0]   chain_in;
    logic [255:0]   base;
    logic [255:0]   stage [0:UNROLL];
    logic [255:0]   sum_words;
    logic           accept;

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] k_word(input logic [5:0] i);
        return K_ROM[32 * (63 - int'(i)) +: 32];
    endfunction

    // One SHA-256 round on the packed working state {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  wt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + wt;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);

`ifdef SHA_MIDSTATE_EN
    logic [255:0] hsave;

    assign chain_in = h_in;
    assign base     = hsave;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsave <= '0;
        end else if (accept) begin
            hsave <= h_in;
        end
    end
`else
    logic unused_h_in;

    assign unused_h_in = ^h_in;
    assign chain_in    = IV;
    assign base        = IV;
`endif

    // Rounds t..t+UNROLL-1 cascaded in one cycle; round j of the cycle reads
    // the j-th word from the top of the shift register.
    always_comb begin
        for (int j = 0; j <= UNROLL; j++) begin
            stage[j] = '0;
        end
        stage[0] = work;
        for (int j = 0; j < UNROLL; j++) begin
            stage[j + 1] = sha_round(stage[j], k_word(t[5:0] + 6'(j)), sched[2047 - 32 * j -: 32]);
        end
    end

    always_comb begin
        sum_words = '0;
        for (int i = 0; i < 8; i++) begin
            sum_words[32 * i +: 32] = base[32 * i +: 32] + work[32 * i +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROUND;
            ROUND:   if (t == LAST_T) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         <= '0;
            sched     <= '0;
            work      <= '0;
            digest    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sched <= w;
                        work  <= chain_in;
                        t     <= '0;
                    end
                end
                ROUND: begin
                    work  <= stage[UNROLL];
                    sched <= sched << SHIFT;
                    t     <= t + 7'(UNROLL);
                end
                FINAL: begin
                    digest    <= sum_words;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_compressor.sv
// tb/tb_sha_compressor.sv - scoreboard bench for sha_compressor at UNROLL 1, 2 and 4
module tb_sha_compressor;

    localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] MID1_DIG  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {
        256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
        192'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
        32'h80000000, 32'h0};
    localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h1c0};

    typedef struct {
        logic [255:0] dig;
        int           acc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           iv1, iv2, iv4;
    logic           rdy1, rdy2, rdy4;
    logic           ov1, ov2, ov4;
    logic [255:0]   dg1, dg2, dg4;
    logic [2047:0]  w;
    logic [255:0]   h_in;

    logic [2047:0]  abc_w, empty_w;
    logic [255:0]   h_used;
    exp_t           q1[$], q2[$], q4[$];
    exp_t           e1, e2, e4;
    int             cyc = 0;
    int             checks = 0;
    int             passes = 0;
    int             fails = 0;
    int             ov1_cnt = 0;

    sha_compressor #(.UNROLL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .w(w), .h_in(h_in), .out_valid(ov1), .digest(dg1));
    sha_compressor #(.UNROLL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
        .w(w), .h_in(h_in), .out_valid(ov2), .digest(dg2));
    sha_compressor #(.UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .w(w), .h_in(h_in), .out_valid(ov4), .digest(dg4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [2047:0] expand(input logic [511:0] blk);
        logic [31:0]   ws [0:63];
        logic [2047:0] r;
        for (int i = 0; i < 16; i++) ws[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) ws[i] = ss1(ws[i - 2]) + ws[i - 7] + ss0(ws[i - 15]) + ws[i - 16];
        for (int i = 0; i < 64; i++) r[2047 - 32 * i -: 32] = ws[i];
        return r;
    endfunction

    function automatic logic [2047:0] junk();
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: every out_valid pulse pops one expectation (digest and latency).
    always @(negedge clk) begin
        if (ov1) begin
            ov1_cnt++;
            chk("sb_nonempty_u1", 256'(q1.size() != 0), 256'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("digest_u1", dg1, e1.dig);
                chk("latency_u1", 256'(cyc - e1.acc), 256'd65);
            end
        end
        if (ov2) begin
            chk("sb_nonempty_u2", 256'(q2.size() != 0), 256'd1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                chk("digest_u2", dg2, e2.dig);
                chk("latency_u2", 256'(cyc - e2.acc), 256'd33);
            end
        end
        if (ov4) begin
            chk("sb_nonempty_u4", 256'(q4.size() != 0), 256'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                chk("digest_u4", dg4, e4.dig);
                chk("latency_u4", 256'(cyc - e4.acc), 256'd17);
            end
        end
    end

    // Offer one block to the DUTs selected by mask {u4,u2,u1}; inputs are
    // scrambled right after the acceptance edge.
    task automatic send(input logic [2:0] mask, input logic [2047:0] ws,
                        input logic [255:0] hs, input logic [255:0] exp);
        int acc;
        @(negedge clk);
        w    = ws;
        h_in = hs;
        if (mask[0]) begin chk("ready_u1", 256'(rdy1), 256'd1); iv1 = 1'b1; end
        if (mask[1]) begin chk("ready_u2", 256'(rdy2), 256'd1); iv2 = 1'b1; end
        if (mask[2]) begin chk("ready_u4", 256'(rdy4), 256'd1); iv4 = 1'b1; end
        @(posedge clk);
        #1;
        acc = cyc;
        if (mask[0]) q1.push_back('{exp, acc});
        if (mask[1]) q2.push_back('{exp, acc});
        if (mask[2]) q4.push_back('{exp, acc});
        iv1  = 1'b0;
        iv2  = 1'b0;
        iv4  = 1'b0;
        w    = junk();
        h_in = ~hs;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q1.size() + q2.size() + q4.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 256'(q1.size() + q2.size() + q4.size()), 256'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, low, n, ovc;
        clk   = 1'b0;
        rst_n = 1'b1;
        iv1   = 1'b0;
        iv2   = 1'b0;
        iv4   = 1'b0;
        w     = '0;
        h_in  = '0;
`ifdef SHA_MIDSTATE_EN
        h_used = IV;
`else
        h_used = ~IV;
`endif
        abc_w   = expand(ABC_BLK);
        empty_w = expand(EMPTY_BLK);

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready_u1", 256'(rdy1), 256'd1);
        chk("rst_ready_u2", 256'(rdy2), 256'd1);
        chk("rst_ready_u4", 256'(rdy4), 256'd1);
        chk("rst_ov_u1", 256'(ov1), 256'd0);
        chk("rst_ov_u2", 256'(ov2), 256'd0);
        chk("rst_ov_u4", 256'(ov4), 256'd0);
        chk("rst_digest_u1", dg1, 256'd0);
        chk("rst_digest_u2", dg2, 256'd0);
        chk("rst_digest_u4", dg4, 256'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(3'b111, abc_w, h_used, ABC_DIG);
        drain("drain_abc");
        send(3'b111, empty_w, h_used, EMPTY_DIG);
        drain("drain_empty");

        // in_valid held high on u1: one block per 66 cycles, in_ready low E1..FINAL.
        @(negedge clk);
        w    = abc_w;
        h_in = h_used;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cyc;
        q1.push_back('{ABC_DIG, acc1});
        w = junk();
        low = 0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            if (!rdy1) low++;
        end
        chk("hold_ready_low_cycles", 256'(low), 256'd65);
        w = empty_w;
        n = 0;
        while (!rdy1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_ready_returns", 256'(rdy1), 256'd1);
        @(posedge clk);
        #1;
        acc2 = cyc;
        q1.push_back('{EMPTY_DIG, acc2});
        iv1 = 1'b0;
        w   = junk();
        chk("hold_accept_period", 256'(acc2 - acc1), 256'd66);
        drain("drain_hold");

        // Reset in the middle of ROUND: the block is discarded silently.
        @(negedge clk);
        w    = abc_w;
        h_in = h_used;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        ovc = ov1_cnt;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready_u1", 256'(rdy1), 256'd1);
        chk("midrst_ov_u1", 256'(ov1), 256'd0);
        chk("midrst_digest_u1", dg1, 256'd0);
        chk("midrst_digest_u4", dg4, 256'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("midrst_no_stale_ov", 256'(ov1_cnt - ovc), 256'd0);
        chk("midrst_digest_held", dg1, 256'd0);
        send(3'b111, abc_w, h_used, ABC_DIG);
        drain("drain_after_reset");

`ifdef SHA_MIDSTATE_EN
        send(3'b111, expand(TWO_BLK1), IV, MID1_DIG);
        drain("drain_two_blk1");
        send(3'b111, expand(TWO_BLK2), MID1_DIG, TWO_DIG);
        drain("drain_two_blk2");
`else
        send(3'b101, empty_w, junk(), EMPTY_DIG);
        drain("drain_hin_ignored");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
